peak_readout: RTL

PEAK_READOUT -- requirements
Module: peak_readout

---
 rtl/peak_readout.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/peak_readout.sv
// Peak readout: snapshots one hisBuilderFSM's per-pixel peaks and streams them
// out as valid/ready beats with a saturated fine-stage window around each peak.
module peak_readout #(
   parameter int NP       = 10,
   parameter int PIX_NUM  = 3,
   parameter int WIN_HALF = 4,
   parameter int IDX_W    = $clog2(PIX_NUM)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             peakValid,
   input  logic [NP-1:0]    peakResult [PIX_NUM],
   input  logic             outReady,
   input  logic             clrOvr,
   output logic             outValid,
   output logic [IDX_W-1:0] outPixel,
   output logic [NP-1:0]    outPeak,
   output logic [NP-1:0]    outWinLo,
   output logic [NP-1:0]    outWinHi,
   output logic             outEmpty,
   output logic             busy,
   output logic             overrun
);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] next_idx;
   logic [NP-1:0]    shadow [PIX_NUM];
   logic             handshake;
   logic             last_beat;
   logic             accept;
   logic             ovr_set;
   logic [NP-1:0]    sel_peak;
   logic             nxt_valid;
   logic [IDX_W-1:0] nxt_pixel;
   logic [NP-1:0]    nxt_peak;
   logic [NP-1:0]    nxt_lo;
   logic [NP-1:0]    nxt_hi;
   logic             nxt_empty;

   function automatic logic [NP-1:0] win_lo(input logic [NP-1:0] peak);
      logic [NP:0] wide;
      wide = {1'b0, peak};
      if (wide >= (NP+1)'(WIN_HALF)) begin
         win_lo = NP'(wide - (NP+1)'(WIN_HALF));
      end else begin
         win_lo = '0;
      end
   endfunction

   function automatic logic [NP-1:0] win_hi(input logic [NP-1:0] peak);
      logic [NP:0] wide;
      wide = {1'b0, peak} + (NP+1)'(WIN_HALF);
      if (wide[NP]) begin
         win_hi = '1;
      end else begin
         win_hi = wide[NP-1:0];
      end
   endfunction

   // A new snapshot is taken when idle, or when the final beat of the current
   // frame is handed off in the same cycle; any other peakValid is an overrun.
   always_comb begin
      handshake = (state == SEND) && outReady;
      last_beat = (idx == IDX_W'(PIX_NUM - 1));
      accept    = peakValid && ((state == IDLE) || (handshake && last_beat));
      ovr_set   = peakValid && (state == SEND) && !(handshake && last_beat);
   end

   // State register.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and next-index logic.
   always_comb begin
      next_state = state;
      next_idx   = idx;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = SEND;
            end else begin
               next_state = IDLE;
            end
         end
         SEND: begin
            if (handshake && last_beat && !accept) begin
               next_state = IDLE;
            end else begin
               next_state = SEND;
            end
         end
         default: next_state = IDLE;
      endcase
      if (accept) begin
         next_idx = '0;
      end else if (handshake && !last_beat) begin
         next_idx = idx + IDX_W'(1);
      end else if (handshake) begin
         next_idx = '0;
      end else begin
         next_idx = idx;
      end
   end

   // Output values for the beat that will be presented after the next edge.
   always_comb begin
      if (accept) begin
         sel_peak = peakResult[0];
      end else begin
         sel_peak = shadow[next_idx];
      end
      if (next_state == SEND) begin
         nxt_valid = 1'b1;
         nxt_pixel = next_idx;
         nxt_peak  = sel_peak;
         nxt_lo    = win_lo(sel_peak);
         nxt_hi    = win_hi(sel_peak);
         nxt_empty = (sel_peak == NP'(0));
      end else begin
         nxt_valid = 1'b0;
         nxt_pixel = '0;
         nxt_peak  = '0;
         nxt_lo    = '0;
         nxt_hi    = '0;
         nxt_empty = 1'b0;
      end
   end

   // Index, snapshot and sticky overrun; a new overrun wins over clrOvr.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         idx     <= '0;
         overrun <= 1'b0;
         for (int i = 0; i < PIX_NUM; i++) begin
            shadow[i] <= '0;
         end
      end else begin
         idx <= next_idx;
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (clrOvr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end
         if (accept) begin
            for (int i = 0; i < PIX_NUM; i++) begin
               shadow[i] <= peakResult[i];
            end
         end
      end
   end

   // Registered beat outputs.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         outValid <= 1'b0;
         outPixel <= '0;
         outPeak  <= '0;
         outWinLo <= '0;
         outWinHi <= '0;
         outEmpty <= 1'b0;
      end else begin
         outValid <= nxt_valid;
         outPixel <= nxt_pixel;
         outPeak  <= nxt_peak;
         outWinLo <= nxt_lo;
         outWinHi <= nxt_hi;
         outEmpty <= nxt_empty;
      end
   end

   assign busy = (state == SEND);

endmodule
